// File: rtl/piso_tx_pkg.sv
// Shared types, defaults and the rotate-priority select used by the PISO transmit scheduler.
package piso_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int unsigned MAX_REQ = 16;

    // One-hot pick of the first set request strictly after ptr, wrapping modulo n.
    function automatic logic [MAX_REQ-1:0] rr_select(
        input logic [MAX_REQ-1:0] req,
        input logic [3:0]         ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] sel;
        logic               found;
        logic [3:0]         idx;
        sel   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if (k <= n) begin
                idx = 4'((32'(ptr) + k) % n);
                if (!found && req[idx]) begin
                    sel[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/piso_tx_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register lives in the scheduler.
module rr_arbiter
    import piso_tx_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  winner_id
);

    logic [MAX_REQ-1:0] req_pad;
    logic [MAX_REQ-1:0] sel;

    assign req_pad = MAX_REQ'(req);
    assign sel     = rr_select(req_pad, 4'(rr_ptr), N_REQ);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_gnt
        assign gnt[gi] = enable & sel[gi];
    end

    // Bits of sel beyond N_REQ are always zero, so folding them in is harmless.
    always_comb begin
        winner_id = '0;
        for (int i = 0; i < int'(MAX_REQ); i++) begin
            if (sel[i]) begin
                winner_id = winner_id | ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler feeding one shared MSB-first PISO shifter; tracks bit times and frame tags.
module piso_tx_scheduler
    import piso_tx_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic                      piso_load,
    output logic [DATA_W-1:0]         piso_data,
    output logic                      bit_valid,
    output logic [ID_W-1:0]           tx_id,
    output logic                      frame_start,
    output logic                      frame_last,
    output logic                      busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [ID_W-1:0]  tx_id_reg, tx_id_next;
    logic [ID_W-1:0]  rr_ptr_reg, rr_ptr_next;
    logic [ID_W-1:0]  winner_id;
    logic             last_bit;
    logic             window;
    logic [DATA_W-1:0] masked_data [N_REQ];

    assign last_bit = (state_reg == SHIFT) && (bit_cnt_reg == CNT_W'(DATA_W - 1));
    // Gating with reset_n keeps gnt quiet while reset is held.
    assign window   = reset_n && en && ((state_reg == IDLE) || last_bit);

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr_reg),
        .enable    (window),
        .gnt       (gnt),
        .winner_id (winner_id)
    );

    assign piso_load = |gnt;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
        assign masked_data[gi] = gnt[gi] ? req_data[gi*DATA_W +: DATA_W] : '0;
    end

    always_comb begin
        piso_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            piso_data = piso_data | masked_data[i];
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        tx_id_next   = tx_id_reg;
        rr_ptr_next  = rr_ptr_reg;
        if (piso_load) begin
            state_next   = SHIFT;
            bit_cnt_next = '0;
            tx_id_next   = winner_id;
            rr_ptr_next  = winner_id;
        end else if (state_reg == SHIFT) begin
            if (last_bit) begin
                state_next   = IDLE;
                bit_cnt_next = '0;
            end else begin
                bit_cnt_next = bit_cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            tx_id_reg   <= '0;
            rr_ptr_reg  <= ID_W'(N_REQ - 1);
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            tx_id_reg   <= tx_id_next;
            rr_ptr_reg  <= rr_ptr_next;
        end
    end

    assign bit_valid   = (state_reg == SHIFT);
    assign busy        = bit_valid;
    assign tx_id       = tx_id_reg;
    assign frame_start = bit_valid && (bit_cnt_reg == '0);
    assign frame_last  = last_bit;

endmodule
